// File: rtl/dmem_access_ctrl_if.sv
// D-cache port bundle: the controller (master) issues registered requests,
// the cache (slave) answers with read data and a busy/stall flag.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_stall_i;

    modport master (
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_stall_i
    );

    modport slave (
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_stall_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns decoder MemRead/MemWrite into one registered
// D-cache request per instruction and stalls the core until it completes.
// Optional DMEM_ACCESS_CTRL_ALIGN_CHK_EN adds misaligned_o and blocks unaligned accesses.
module dmem_access_ctrl #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
    output logic              misaligned_o,
`endif
    dmem_access_ctrl_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_reg, state_next;
    logic              stall_next;
    logic              req;
    logic              misal;
    logic              mem_read_reg, mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    assign req = MemRead_i | MemWrite_i;

`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
    logic misaligned_reg;
    assign misal        = |addr_i[1:0];
    assign misaligned_o = misaligned_reg;
`else
    logic unused_addr_lo;
    assign misal          = 1'b0;
    assign unused_addr_lo = ^addr_i[1:0];
`endif

    always_comb begin
        state_next = state_reg;
        stall_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall_next = 1'b1;
                    state_next = misal ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall_next = 1'b1;
                if (!mem.mem_stall_i) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The request decode is combinational, so gate it with reset to keep the core free.
    assign stall_o = stall_next & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            rdata_reg      <= '0;
            stall_cnt_reg  <= '0;
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
            misaligned_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (stall_o && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (req) begin
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
                        if (misal) begin
                            misaligned_reg <= 1'b1;
                            if (MemRead_i && !MemWrite_i) rdata_reg <= '0;
                        end else
`endif
                        begin
                            mem_addr_reg  <= addr_i[ADDR_W+1:2];
                            mem_wdata_reg <= wdata_i;
                            // A store wins when the decoder asserts both.
                            mem_write_reg <= MemWrite_i;
                            mem_read_reg  <= MemRead_i & ~MemWrite_i;
                        end
                    end
                end
                ACCESS: begin
                    if (!mem.mem_stall_i) begin
                        if (mem_read_reg) rdata_reg <= mem.mem_rdata_i;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                    end
                end
                DONE: begin
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
                    misaligned_reg <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_read_o  = mem_read_reg;
    assign mem.mem_write_o = mem_write_reg;
    assign mem.mem_addr_o  = mem_addr_reg;
    assign mem.mem_wdata_o = mem_wdata_reg;
    assign rdata_o         = rdata_reg;
    assign stall_cnt_o     = stall_cnt_reg;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases then random transactions, each
// checked against a transaction-level model (latency, request count, load data, stall total).
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o;
    logic [15:0] stall_cnt_o;
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
    logic        misaligned_o;
    logic        sat_misal;
`endif
    logic        sat_req;
    logic [31:0] sat_rdata;
    logic        sat_stall;
    logic [3:0]  sat_cnt;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(30), .DATA_W(32)) mif ();
    dmem_access_ctrl_if #(.ADDR_W(30), .DATA_W(32)) sif ();

    dmem_access_ctrl #(.ADDR_W(30), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o),
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
        .misaligned_o(misaligned_o),
`endif
        .mem(mif)
    );

    dmem_access_ctrl #(.ADDR_W(30), .DATA_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .MemRead_i(sat_req), .MemWrite_i(1'b0),
        .addr_i(32'h0), .wdata_i(32'h0), .rdata_o(sat_rdata), .stall_o(sat_stall),
        .stall_cnt_o(sat_cnt),
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
        .misaligned_o(sat_misal),
`endif
        .mem(sif)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;
    logic [31:0] m_rdata;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One memory instruction: present it, let the cache stall for nstall ACCESS cycles,
    // then compare what was observed against the rules for that instruction.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdat, input int nstall);
        int stall_cyc = 0;
        int req_cyc   = 0;
        bit done      = 0;
        bit bad       = 0;
        bit misal     = 0;
        int exp_stall, exp_req;
        @(posedge clk); #1;
        MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wd;
        mif.mem_rdata_i = rdat;
        mif.mem_stall_i = (nstall > 0);
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (stall_o) stall_cyc++;
            else done = 1;
            if (mif.mem_read_o || mif.mem_write_o) begin
                req_cyc++;
                if (mif.mem_addr_o !== addr[31:2] || mif.mem_wdata_o !== wd ||
                    mif.mem_write_o !== wr || mif.mem_read_o !== (rd & ~wr)) bad = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                mif.mem_stall_i = (req_cyc < nstall);
            end
        end
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
        misal = (addr[1:0] != 2'b00);
`endif
        exp_stall = misal ? 1 : 2 + nstall;
        exp_req   = misal ? 0 : 1 + nstall;
        if (rd && !wr) m_rdata = misal ? 32'h0 : rdat;
        m_cnt = (m_cnt + exp_stall > 65535) ? 65535 : m_cnt + exp_stall;
        n_txn++;
        $display("txn %0d rd=%0d wr=%0d addr=%h nstall=%0d stall_cyc=%0d req_cyc=%0d rdata=%h cnt=%0d",
                 n_txn, rd, wr, addr, nstall, stall_cyc, req_cyc, rdata_o, stall_cnt_o);
        check("done_reached", done, 1);
        check("stall_cycles", stall_cyc, exp_stall);
        check("req_cycles", req_cyc, exp_req);
        check("req_fields", bad, 0);
        check("rdata", rdata_o, m_rdata);
        check("stall_cnt", stall_cnt_o, m_cnt);
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
        check("misaligned_done", misaligned_o, misal);
`endif
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        MemRead_i = 0; MemWrite_i = 0;
        @(negedge clk);
        check("idle_stall", stall_o, 0);
        check("idle_req", {mif.mem_read_o, mif.mem_write_o}, 2'b00);
    endtask

    initial begin
        bit rd, wr;
        int kind;
        logic [31:0] a;
        rst_n = 0; MemRead_i = 0; MemWrite_i = 0; addr_i = 0; wdata_i = 0;
        mif.mem_rdata_i = 0; mif.mem_stall_i = 0;
        sif.mem_rdata_i = 0; sif.mem_stall_i = 0; sat_req = 0;
        m_rdata = 0; m_cnt = 0;
        #3;
        check("reset_stall", stall_o, 0);
        check("reset_req", {mif.mem_read_o, mif.mem_write_o}, 2'b00);
        check("reset_addr", mif.mem_addr_o, 0);
        check("reset_rdata", rdata_o, 0);
        check("reset_cnt", stall_cnt_o, 0);
        @(posedge clk); #1;
        rst_n = 1;

        do_txn(1, 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
        do_txn(0, 1, 32'h0000_0020, 32'hDEAD_BEEF, $urandom, 3);
        do_txn(1, 0, 32'h0000_0000, 32'h0, 32'hA5A5_0001, 0);
        do_txn(1, 0, 32'h0000_0004, 32'h0, 32'h5A5A_0002, 0);
        do_txn(1, 1, 32'h0000_0008, 32'h1111_2222, 32'hCAFE_F00D, 0);
        idle_cycle();

        // Asynchronous reset in the middle of a stalled access.
        @(posedge clk); #1;
        MemRead_i = 1; MemWrite_i = 0; addr_i = 32'h40; wdata_i = 32'h77;
        mif.mem_stall_i = 1;
        @(negedge clk);
        check("rst_req_stall", stall_o, 1);
        @(negedge clk);
        check("rst_in_access", mif.mem_read_o, 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_stall", stall_o, 0);
        check("rst_async_req", {mif.mem_read_o, mif.mem_write_o}, 2'b00);
        check("rst_async_addr", mif.mem_addr_o, 0);
        check("rst_async_wdata", mif.mem_wdata_o, 0);
        check("rst_async_rdata", rdata_o, 0);
        check("rst_async_cnt", stall_cnt_o, 0);
        @(posedge clk); #1;
        MemRead_i = 0; mif.mem_stall_i = 0; rst_n = 1;
        m_rdata = 0; m_cnt = 0;
        @(negedge clk);
        check("post_rst_stall", stall_o, 0);
        check("post_rst_cnt", stall_cnt_o, 0);
        do_txn(1, 0, 32'h0000_0100, 32'h0, 32'h0BAD_CAFE, 1);

`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
        do_txn(1, 0, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 0);
        @(posedge clk); #1;
        MemRead_i = 0;
        @(negedge clk);
        check("misaligned_clear", misaligned_o, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            rd = (kind == 0) || (kind == 2) || (kind == 3);
            wr = (kind == 1) || (kind == 2);
            a = $urandom;
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHK_EN
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
            do_txn(rd, wr, a, $urandom, $urandom, $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // Saturation of a 4-bit stall counter under back-to-back loads.
        check("sat_start", sat_cnt, 0);
        @(posedge clk); #1;
        sat_req = 1;
        repeat (3) @(negedge clk);
        check("sat_one_txn", sat_cnt, 2);
        repeat (40) @(negedge clk);
        check("sat_hold", sat_cnt, 4'hF);
        repeat (7) @(negedge clk);
        check("sat_no_wrap", sat_cnt, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Executes the memory operations the main decoder requests. Takes MemRead/MemWrite plus the ALU address and store data, and runs a registered request/stall handshake with the data cache.
- Freezes the core with stall_o until each access completes, and returns load data.
- Sits between the datapath/decoder outputs and the D-cache port of the single-cycle RISC-V core.

Parameters:
ADDR_W, 30, word-address width driven to the cache (byte address bits [ADDR_W+1:2])
DATA_W, 32, data word width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
MemRead_i  input  1  load request from the decoder
MemWrite_i  input  1  store request from the decoder
addr_i  input  32  byte address (ALU result, rs1+imm)
wdata_i  input  DATA_W  store data (rs2)
rdata_o  output  DATA_W  load data to MemtoReg mux, registered
stall_o  output  1  core hold (PC and register file write gated while 1)
mem_read_o  output  1  cache read request, registered
mem_write_o  output  1  cache write request, registered
mem_addr_o  output  ADDR_W  cache word address, registered
mem_wdata_o  output  DATA_W  cache write data, registered
mem_rdata_i  input  DATA_W  cache read data, valid when mem_stall_i=0
mem_stall_i  input  1  cache busy; request must be held while 1
stall_cnt_o  output  CNT_W  total cycles stall_o was 1, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rdata_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, stall_cnt_o=0. stall_o=0. Any in-flight request is dropped immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stall_o=0, cache outputs 0.
- IDLE, MemRead_i|MemWrite_i: stall_o=1 combinationally in that cycle.
  - Next edge: capture addr_i[ADDR_W+1:2] into mem_addr_o and wdata_i into mem_wdata_o.
  - Next edge: set mem_write_o=MemWrite_i, mem_read_o=MemRead_i & ~MemWrite_i. Both inputs set means write only.
  - Next edge: go to ACCESS.
- ACCESS: stall_o=1; all mem_* outputs held stable.
  - Edge with mem_stall_i=1: remain in ACCESS.
  - Edge with mem_stall_i=0: rdata_o<=mem_rdata_i if the access was a read (rdata_o unchanged on a write); mem_read_o/mem_write_o<=0; go to DONE.
  - The cache is sampled no earlier than the first ACCESS cycle.
- DONE: stall_o=0 and rdata_o valid; the core commits and advances at this edge.
  - Requests are ignored in DONE, because the same instruction's MemRead/MemWrite are still asserted.
  - Unconditional transition to IDLE.
- Latency: minimum 2 stall cycles (IDLE request cycle + one ACCESS cycle). Each extra mem_stall_i=1 cycle in ACCESS adds 1.
- mem_stall_i is ignored in IDLE and DONE.
- Back-to-back memory instructions: DONE→IDLE→new request. Exactly one cache request per instruction.
- stall_cnt_o: +1 on every edge where stall_o=1. Holds at all-ones (no wrap).
- addr_i[1:0] is ignored unless the optional feature is enabled.

Optional Feature:
DMEM_ACCESS_CTRL_ALIGN_CHK_EN
- Defined:
  - Extra output misaligned_o (1 bit, reset 0).
  - An IDLE request with addr_i[1:0]≠0 issues no cache request; the FSM goes straight to DONE.
  - In that case misaligned_o=1 during DONE, rdata_o<=0 for loads, and stall_o is 1 for the request cycle only.
  - misaligned_o clears on leaving DONE.
- Undefined: port absent; low address bits are silently dropped.

Test Plan:
1. Load, no cache stall: MemRead_i=1, addr_i=0x0000_0010, mem_stall_i=0, mem_rdata_i=0x1234_5678.
   → mem_addr_o=0x4 and mem_read_o=1 for exactly 1 cycle; stall_o=1 for 2 cycles; rdata_o=0x1234_5678 in DONE; stall_cnt_o=2.
2. Store, cache stall: MemWrite_i=1, addr_i=0x20, wdata_i=0xDEADBEEF, mem_stall_i=1 for the first 3 ACCESS cycles.
   → mem_write_o held 4 cycles with mem_addr_o=0x8 and mem_wdata_o=0xDEADBEEF stable; stall_o=1 for 5 cycles; rdata_o unchanged.
3. Back-to-back loads at 0x0 then 0x4, no cache stall.
   → exactly two mem_read_o pulses, at cycles 1 and 4 with mem_addr_o 0x0 then 0x1; no re-issue during DONE.
4. MemRead_i=MemWrite_i=1, addr_i=0x8.
   → only mem_write_o=1 and mem_read_o stays 0; rdata_o unchanged.
5. rst_n pulled low mid-ACCESS (mem_stall_i=1).
   → all outputs 0 without waiting for a clock edge; after release, the FSM is in IDLE and stall_cnt_o=0.
6. With DMEM_ACCESS_CTRL_ALIGN_CHK_EN: load at addr_i=0x6.
   → no mem_read_o; misaligned_o=1 and rdata_o=0 one cycle after the request.
   Separately, force stall_cnt_o near saturation (CNT_W=4): it stops at 0xF.
